// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch front end.
//   fetch_state_e : fetch FSM states (REQ, WAIT, HOLD, DISCARD)
//   NOP_INST      : bubble instruction (opcode 00001) placed in IF/ID
package fetch_pkg;

  localparam logic [15:0] NOP_INST = 16'h0800;

  // REQ     : request issued from the live PC this cycle
  // WAIT    : request outstanding, address replayed from req_addr
  // HOLD    : response parked in the skid buffer while decode stalls
  // DISCARD : outstanding response belongs to a flushed path
  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register {inst, pc_nx, valid}.
//   clk, rst      : clock, synchronous active-low reset to {NOP, 0, 0}
//   load_i        : capture inst_i/pc_nx_i as a real instruction
//   bubble_i      : insert a NOP bubble (valid 0)
//   neither       : hold
//   inst_o, pc_nx_o, valid_o : registered contents
module ifid_reg #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] NOP  = fetch_pkg::NOP_INST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             bubble_i,
  input  logic [WIDTH-1:0] inst_i,
  input  logic [WIDTH-1:0] pc_nx_i,
  output logic [WIDTH-1:0] inst_o,
  output logic [WIDTH-1:0] pc_nx_o,
  output logic             valid_o
);
  import fetch_pkg::*;

  logic [WIDTH-1:0] inst_q, pc_nx_q;
  logic             valid_q;

  // Bubble keeps the old pc_nx; only inst/valid describe an empty slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      inst_q  <= NOP;
      pc_nx_q <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      inst_q  <= inst_i;
      pc_nx_q <= pc_nx_i;
      valid_q <= 1'b1;
    end else if (bubble_i) begin
      inst_q  <= NOP;
      valid_q <= 1'b0;
    end
  end

  assign inst_o  = inst_q;
  assign pc_nx_o = pc_nx_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: fetch control between the PC register and decode.
//   clk, rst                : clock, synchronous active-low reset
//   pc_addr, pc_nx          : current PC and PC+2 from the PC register
//   imem_rdata/done/stall   : variable-latency memory response
//   id_stall, flush         : decode hazard stall, branch/jump redirect
//   imem_rd, imem_addr      : memory read request
//   pc_en                   : PC register write enable
//   id_inst/id_pc_nx/id_valid : IF/ID register contents
module if_id_stage #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_addr,
  input  logic [WIDTH-1:0] pc_nx,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_done,
  input  logic             imem_stall,
  input  logic             id_stall,
  input  logic             flush,
  output logic             imem_rd,
  output logic [WIDTH-1:0] imem_addr,
  output logic             pc_en,
  output logic [WIDTH-1:0] id_inst,
  output logic [WIDTH-1:0] id_pc_nx,
  output logic             id_valid
);
  import fetch_pkg::*;

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] req_addr_q, req_addr_d;
  logic [WIDTH-1:0] skid_inst_q, skid_pc_nx_q;
  logic             skid_ld, ifid_ld, ifid_bub, pc_en_d, rsp;
  logic [WIDTH-1:0] ld_inst, ld_pc_nx;

  assign rsp = imem_done & ~imem_stall;

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    skid_ld    = 1'b0;
    ifid_ld    = 1'b0;
    ifid_bub   = 1'b0;
    pc_en_d    = 1'b0;
    case (state_q)
      S_REQ, S_WAIT: begin
        // Request outlives this cycle: freeze its address, since the PC
        // may move (on flush) before the response arrives.
        if (state_q == S_REQ && !rsp) req_addr_d = pc_addr;
        if (rsp) begin
          if (flush) begin
            ifid_bub = 1'b1;
            pc_en_d  = 1'b1;
            state_d  = S_REQ;
          end else if (id_stall) begin
            skid_ld  = 1'b1;
            state_d  = S_HOLD;
          end else begin
            ifid_ld  = 1'b1;
            pc_en_d  = 1'b1;
            state_d  = S_REQ;
          end
        end else if (flush) begin
          ifid_bub = 1'b1;
          pc_en_d  = 1'b1;
          state_d  = S_DISCARD;
        end else begin
          ifid_bub = ~id_stall;
          state_d  = S_WAIT;
        end
      end
      S_DISCARD: begin
        // Stale response is swallowed; a newer redirect still moves the PC.
        pc_en_d  = flush;
        ifid_bub = flush | ~id_stall;
        if (rsp) state_d = S_REQ;
      end
      S_HOLD: begin
        if (flush) begin
          ifid_bub = 1'b1;
          pc_en_d  = 1'b1;
          state_d  = S_REQ;
        end else if (!id_stall) begin
          ifid_ld  = 1'b1;
          pc_en_d  = 1'b1;
          state_d  = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_REQ;
      req_addr_q   <= '0;
      skid_inst_q  <= '0;
      skid_pc_nx_q <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      if (skid_ld) begin
        skid_inst_q  <= imem_rdata;
        skid_pc_nx_q <= pc_nx;
      end
    end
  end

  // HOLD drains the skid; every other load comes straight from memory.
  assign ld_inst  = (state_q == S_HOLD) ? skid_inst_q  : imem_rdata;
  assign ld_pc_nx = (state_q == S_HOLD) ? skid_pc_nx_q : pc_nx;

  assign imem_rd   = rst & (state_q != S_HOLD);
  assign imem_addr = (state_q == S_REQ) ? pc_addr : req_addr_q;
  assign pc_en     = rst & pc_en_d;

  ifid_reg #(.WIDTH(WIDTH), .NOP(NOP_INST)) u_ifid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (ifid_ld),
    .bubble_i (ifid_bub),
    .inst_i   (ld_inst),
    .pc_nx_i  (ld_pc_nx),
    .inst_o   (id_inst),
    .pc_nx_o  (id_pc_nx),
    .valid_o  (id_valid)
  );

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: bench for if_id_stage. A PC-register model and a
// variable-latency memory model drive the DUT. Every sequential PC advance
// from address p means decode must next see {mem[p], p+2}; that pair is
// queued and a monitor compares it against each fresh IF/ID load.
module tb_if_id_stage;
  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc_addr = '0, pc_nx = '0, imem_rdata = '0;
  logic        imem_done = 1'b0, imem_stall = 1'b0, id_stall = 1'b0, flush = 1'b0;
  logic        imem_rd, pc_en, id_valid;
  logic [15:0] imem_addr, id_inst, id_pc_nx;

  if_id_stage dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_nx(pc_nx),
    .imem_rdata(imem_rdata), .imem_done(imem_done), .imem_stall(imem_stall),
    .id_stall(id_stall), .flush(flush), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .pc_en(pc_en), .id_inst(id_inst), .id_pc_nx(id_pc_nx), .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] inst; logic [15:0] pcnx; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] mem_arr [0:2047];

  int          n_chk = 0, n_fail = 0;
  logic [15:0] pc = '0;          // PC register model
  bit          busy = 1'b0;      // memory has an accepted-but-unanswered request
  logic [15:0] m_addr = '0;
  int          m_cnt = 0;
  bit          open_x = 1'b0;    // IF/ID is overwritten at the coming edge
  logic        s_rd, s_pcen;
  logic [15:0] s_addr;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endfunction

  // One clock cycle; entered and left just after a rising edge.
  task automatic step(input bit r, input bit fl, input bit st, input logic [15:0] tgt,
                      input int lat, input bit mst);
    bit acc;
    rst = r; flush = fl; id_stall = st; pc_addr = pc; pc_nx = pc + 16'd2;
    #1;
    if (r && !busy && imem_rd) begin
      busy = 1'b1; m_addr = imem_addr; m_cnt = lat;
    end
    if (r && busy && m_cnt == 0) begin
      imem_done = 1'b1; imem_rdata = mem_arr[m_addr[11:1]]; imem_stall = mst;
    end else begin
      imem_done = 1'b0; imem_rdata = 16'($urandom); imem_stall = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    s_rd = imem_rd; s_addr = imem_addr; s_pcen = pc_en;
    acc = r && busy && m_cnt == 0 && !mst;
    if (!r) begin
      chk("rst_imem_rd", s_rd, 0);
      chk("rst_pc_en", s_pcen, 0);
    end else if (busy) begin
      chk("mem_rd_held", s_rd, 1);
      chk("mem_addr_held", s_addr, m_addr);
      if (!acc && !fl) chk("pc_en_outstanding", s_pcen, 0);
    end
    if (s_pcen && !fl) exp_q.push_back('{mem_arr[pc[11:1]], pc + 16'd2});
    open_x = !r || !st || fl;
    @(posedge clk);
    #1;
    if (!r) begin
      busy = 1'b0; pc = '0;
    end else begin
      if (acc) busy = 1'b0;
      else if (busy && m_cnt > 0) m_cnt--;
      if (s_pcen) pc = fl ? tgt : pc + 16'd2;
    end
  endtask

  // Monitor: every fresh IF/ID load is either the next expected instruction
  // or a NOP bubble with nothing pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (open_x) begin
        if (id_valid) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected", {16'h0, id_inst}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("sb_inst", id_inst, e.inst);
            chk("sb_pc_nx", id_pc_nx, e.pcnx);
          end
        end else begin
          chk("sb_bubble_inst", id_inst, NOP);
          chk("sb_lost", exp_q.size(), 0);
        end
      end
    end
  end

  initial begin
    bit r, fl, st, mst;
    logic [15:0] tgt;
    int lat;
    for (int i = 0; i < 2048; i++) mem_arr[i] = 16'($urandom);
    mem_arr[0] = 16'h1234; mem_arr[1] = 16'h5678;
    mem_arr[8] = 16'h4321; mem_arr[9] = 16'hABCD;

    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("reset_inst", id_inst, NOP);
    chk("reset_valid", id_valid, 0);
    chk("reset_pc_nx", id_pc_nx, 0);

    // zero-wait memory, back-to-back
    step(1, 0, 0, 0, 0, 0);
    chk("zw_pc_en0", s_pcen, 1);
    chk("zw_inst0", id_inst, 16'h1234);
    chk("zw_pcnx0", id_pc_nx, 16'h0002);
    step(1, 0, 0, 0, 0, 0);
    chk("zw_pc_en1", s_pcen, 1);
    chk("zw_inst1", id_inst, 16'h5678);

    // redirect to 0x0010, then 3-cycle latency
    step(1, 1, 0, 16'h0010, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 3, 0);
      chk("lat_addr", s_addr, 16'h0010);
      chk("lat_pc_en", s_pcen, 0);
      chk("lat_valid", id_valid, 0);
      chk("lat_inst", id_inst, NOP);
    end
    step(1, 0, 0, 0, 0, 0);
    chk("lat_done_inst", id_inst, 16'h4321);

    // response during decode stall parks in the skid
    step(1, 0, 1, 0, 0, 0);
    chk("skid_pc_en", s_pcen, 0);
    chk("skid_held", id_inst, 16'h4321);
    step(1, 0, 1, 0, 0, 0);
    chk("hold_rd", s_rd, 0);
    chk("hold_held", id_inst, 16'h4321);
    step(1, 0, 0, 0, 0, 0);
    chk("hold_rel_pc_en", s_pcen, 1);
    chk("hold_rel_inst", id_inst, 16'hABCD);
    chk("hold_rel_pcnx", id_pc_nx, 16'h0014);

    // flush during WAIT: stale 0x0020 response discarded
    step(1, 1, 0, 16'h0020, 0, 0);
    step(1, 0, 0, 0, 2, 0);
    chk("wait_addr", s_addr, 16'h0020);
    step(1, 1, 0, 16'h0100, 0, 0);
    chk("wflush_pc_en", s_pcen, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("disc_addr", s_addr, 16'h0020);
    chk("disc_inst", id_inst, NOP);
    chk("disc_valid", id_valid, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("redir_addr", s_addr, 16'h0100);
    chk("redir_wait_inst", id_inst, NOP);
    step(1, 0, 0, 0, 0, 0);
    chk("redir_inst", id_inst, mem_arr[128]);

    // flush + stall while holding
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 16'h0200, 0, 0);
    chk("hflush_pc_en", s_pcen, 1);
    chk("hflush_inst", id_inst, NOP);
    chk("hflush_valid", id_valid, 0);

    // reset while a response is pending
    step(1, 0, 0, 0, 3, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("mrst_valid", id_valid, 0);
    chk("mrst_inst", id_inst, NOP);
    step(1, 0, 0, 0, 0, 0);
    chk("mrst_refetch", id_inst, 16'h1234);

    // randomized traffic
    repeat (3000) begin
      r   = ($urandom_range(0, 199) != 0);
      fl  = ($urandom_range(0, 11) == 0);
      st  = ($urandom_range(0, 2) == 0);
      tgt = 16'($urandom_range(0, 2047));
      tgt = tgt << 1;
      lat = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
      mst = ($urandom_range(0, 5) == 0);
      step(r, fl, st, tgt, lat, mst);
    end
    step(1, 0, 0, 0, 0, 0);
    #5;
    chk("sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Fetch-side companion to the PC register in the 16-bit pipelined core. It drives the instruction-memory request from the current PC and handles a variable-latency memory (done/stall handshake). It produces the PC write-enable and loads the IF/ID pipeline register consumed by decode. Decode stalls are absorbed in a one-entry skid buffer, and branch/jump flushes are handled by inserting NOP bubbles and discarding stale responses.

Parameters:
- WIDTH, 16: instruction and address width.
- NOP_INST, 16'h0800: bubble encoding (opcode 00001).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 at a rising edge resets).
- pc_addr  in  WIDTH  current PC from the PC register.
- pc_nx  in  WIDTH  PC+2 from the PC register.
- imem_rdata  in  WIDTH  instruction returned by memory.
- imem_done  in  1  response valid this cycle.
- imem_stall  in  1  memory busy; qualifies done (response accepted only when done & ~imem_stall).
- id_stall  in  1  decode hazard stall.
- flush  in  1  redirect (branch taken or jump).
- imem_rd  out  1  read request.
- imem_addr  out  WIDTH  request address.
- pc_en  out  1  PC register write enable.
- id_inst  out  WIDTH  IF/ID instruction.
- id_pc_nx  out  WIDTH  IF/ID PC+2.
- id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset values: state=REQ, id_inst=NOP_INST, id_pc_nx=0, id_valid=0, skid empty, req_addr=0. imem_rd=0 and pc_en=0 while rst==0.
- "rsp" means imem_done & ~imem_stall.
- imem_addr = pc_addr in REQ; req_addr in all other states.
- imem_rd = 1 in REQ, WAIT and DISCARD; 0 in HOLD.
- Memory rule: the address is held stable from request until rsp, so req_addr is captured from pc_addr when leaving REQ without rsp.
- States and transitions:
  - REQ / WAIT, rsp & flush: IF/ID<=NOP (valid 0), pc_en=1, ->REQ.
  - REQ / WAIT, rsp & ~flush & id_stall: skid<={imem_rdata,pc_nx}, IF/ID held, pc_en=0, ->HOLD.
  - REQ / WAIT, rsp & ~flush & ~id_stall: IF/ID<={imem_rdata,pc_nx}, valid 1, pc_en=1, ->REQ.
  - REQ / WAIT, ~rsp & flush: IF/ID<=NOP, pc_en=1 (PC takes target), ->DISCARD.
  - REQ / WAIT, ~rsp & ~flush: pc_en=0, ->WAIT. IF/ID is held if id_stall, else loaded with NOP (valid 0).
  - DISCARD: waits for the stale response and never latches it; pc_en=flush (a newer redirect is still accepted). IF/ID<=NOP unless id_stall&~flush. rsp ->REQ, else stay.
  - HOLD, flush: skid dropped, IF/ID<=NOP, pc_en=1, ->REQ.
  - HOLD, ~flush & ~id_stall: IF/ID<=skid (valid 1), pc_en=1, ->REQ.
  - HOLD, ~flush & id_stall: stay, everything held, pc_en=0.
- Priority: reset > flush > id_stall.
- Latency: with single-cycle memory (done in the REQ cycle) and no stalls, an instruction reaches id_inst at the next edge. Throughput is 1 instruction per cycle.
- Reset mid-request: the state returns to REQ and the outstanding response is not tracked. The memory is reset by the same rst.
- pc_en is never 1 while a request is outstanding unless flush=1. This keeps imem_addr stable because it is taken from req_addr in WAIT.

Decomposition:
- Package fetch_pkg: state enum (REQ, WAIT, HOLD, DISCARD) and constant NOP_INST.
- Sub-module ifid_reg: the WIDTH+WIDTH+1 pipeline register with load, bubble and hold controls and synchronous active-low reset to {NOP_INST,0,0}.
- FSM and skid buffer stay in if_id_stage.

Test Plan:
- Zero-wait memory, no stalls, PC 0x0000 then 0x0002, rdata 0x1234 then 0x5678: id_inst=0x1234 (id_pc_nx=0x0002) after edge 1, then 0x5678 after edge 2; pc_en=1 every cycle.
- done delayed 3 cycles at pc 0x0010: imem_addr stays 0x0010 and pc_en=0 for 3 cycles; id_valid=0 with id_inst=0x0800 meanwhile; the instruction latches on the done cycle.
- Response 0xABCD arrives with id_stall=1 for 2 cycles: IF/ID unchanged, state HOLD, imem_rd=0. On id_stall release id_inst=0xABCD and pc_en=1.
- flush asserted during WAIT at 0x0020, then PC loads 0x0100: stale response for 0x0020 is discarded. The next request is 0x0100 and id_inst stays 0x0800 until it returns.
- flush and id_stall together in HOLD: skid dropped, id_inst=0x0800, id_valid=0, pc_en=1.
- rst=0 held in WAIT with done pending: after the edge, state=REQ, id_valid=0, id_inst=0x0800; imem_rd=0 while rst=0.
